// File: rtl/state_pred_buffer.sv
// state_pred_buffer: captures the predicted state vector on a rising edge of SCU_Done into a
// two-bank ping-pong buffer and streams it element by element over a valid/ready handshake.
module state_pred_buffer #(
    parameter int unsigned DWIDTH = 64,
    parameter int unsigned N      = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N-1:0][DWIDTH-1:0]   X_k1k,
    input  logic                       SCU_Done,
    output logic [DWIDTH-1:0]          out_data,
    output logic [3:0]                 out_idx,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       frame_done,
    output logic                       busy,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt
);

    localparam logic [3:0] LastIdx = 4'(N - 1);

    typedef enum logic {StIdle, StStream} state_e;

    state_e            state;
    logic              done_q;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic [1:0]        count_next;
    logic [3:0]        idx;
    logic [DWIDTH-1:0] bank [2][N];

    logic capture;
    logic rel;
    logic accept;

    // Event decode: capture edge, release of the last element, and whether a capture fits.
    always_comb begin
        capture = SCU_Done & ~done_q;
        rel     = (state == StStream) & out_ready & (idx == LastIdx);
        // A release in the same cycle frees the bank being written, so a full buffer still accepts.
        accept  = capture & ((count != 2'd2) | rel);
    end

    // Occupancy next-state: simultaneous capture and release leave the count unchanged.
    always_comb begin
        count_next = count;
        unique case ({accept, rel})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    // Bank storage; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < int'(N); i++) begin
                bank[wr_ptr][i] <= X_k1k[i];
            end
        end
    end

    // Capture/release bookkeeping, frame_done pulse and overflow accounting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q     <= 1'b1;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            drop_cnt   <= 8'd0;
        end else begin
            done_q     <= SCU_Done;
            count      <= count_next;
            frame_done <= rel;
            if (accept) begin
                wr_ptr <= ~wr_ptr;
            end
            if (rel) begin
                rd_ptr <= ~rd_ptr;
            end
            if (capture && !accept) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

    // Reader FSM: walks idx across the current bank, chaining straight into the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StIdle;
            idx   <= 4'd0;
        end else begin
            unique case (state)
                StIdle: begin
                    idx <= 4'd0;
                    if (count != 2'd0) begin
                        state <= StStream;
                    end
                end
                StStream: begin
                    if (out_ready) begin
                        if (idx == LastIdx) begin
                            idx <= 4'd0;
                            if (count_next == 2'd0) begin
                                state <= StIdle;
                            end
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                    idx   <= 4'd0;
                end
            endcase
        end
    end

    // Output decode; the bank read is combinational so a same-cycle overwrite lands after the edge.
    always_comb begin
        out_valid = (state == StStream);
        out_data  = out_valid ? bank[rd_ptr][idx] : '0;
        out_idx   = out_valid ? idx : 4'd0;
        out_last  = out_valid & (idx == LastIdx);
        busy      = (count != 2'd0) | out_valid;
    end

endmodule

// File: tb/tb_state_pred_buffer.sv
// Scoreboard bench for state_pred_buffer: stimulus pushes expected elements, a negedge monitor
// pops and compares on every transfer and checks handshake rules every cycle.
module tb_state_pred_buffer;

    localparam int N  = 12;
    localparam int DW = 64;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [N-1:0][DW-1:0] X_k1k;
    logic               SCU_Done = 1'b0;
    logic [DW-1:0]      out_data;
    logic [3:0]         out_idx;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic               out_last;
    logic               frame_done;
    logic               busy;
    logic               overflow;
    logic [7:0]         drop_cnt;

    state_pred_buffer #(.DWIDTH(DW), .N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .X_k1k      (X_k1k),
        .SCU_Done   (SCU_Done),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .frame_done (frame_done),
        .busy       (busy),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  idx;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   fd_seen = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lat < 0: untimed; otherwise element 0 is expected lat cycles after the capture cycle.
    task automatic capture(input logic [63:0] base, input bit push, input int lat);
        exp_t e;
        for (int i = 0; i < N; i++) X_k1k[i] = base + 64'(i);
        SCU_Done = 1'b1;
        if (push) begin
            for (int i = 0; i < N; i++) begin
                e.data = base + 64'(i);
                e.idx  = 4'(i);
                e.last = (i == N - 1);
                e.cyc  = (lat < 0) ? -1 : cyc + lat + i;
                sb.push_back(e);
            end
        end
        tick();
        SCU_Done = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300 && (busy || sb.size() != 0); i++) tick();
        check({name, " busy"}, 64'(busy), 64'd0);
        check({name, " pending"}, 64'(sb.size()), 64'd0);
        tick();
        tick();
    endtask

    // Monitor: frame_done timing, zero gating, no mid-frame drop, hold stability, data order.
    initial begin
        bit          fd_exp = 1'b0;
        bit          in_frame = 1'b0;
        bit          hold = 1'b0;
        logic [63:0] hold_data = '0;
        logic [3:0]  hold_idx = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                fd_exp   = 1'b0;
                in_frame = 1'b0;
                hold     = 1'b0;
            end else begin
                check("frame_done", 64'(frame_done), 64'(fd_exp));
                if (frame_done) fd_seen++;
                if (!out_valid) begin
                    check("idle data", out_data, 64'd0);
                    check("idle last", 64'(out_last), 64'd0);
                end
                if (in_frame) check("valid mid-frame", 64'(out_valid), 64'd1);
                if (hold) begin
                    check("held data", out_data, hold_data);
                    check("held idx", 64'(out_idx), 64'(hold_idx));
                end
                fd_exp = 1'b0;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL unexpected element: got idx %0d data %0h, none expected",
                                 out_idx, out_data);
                    end else begin
                        e = sb.pop_front();
                        check("elem data", out_data, e.data);
                        check("elem idx", 64'(out_idx), 64'(e.idx));
                        check("elem last", 64'(out_last), 64'(e.last));
                        if (e.cyc >= 0) check("elem cycle", 64'(cyc), 64'(e.cyc));
                    end
                    fd_exp = out_last;
                end
                in_frame  = out_valid && !(out_ready && out_last);
                hold      = out_valid && !out_ready;
                hold_data = out_data;
                hold_idx  = out_idx;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) X_k1k[i] = '0;
        #1;
        // Reset state
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_data", out_data, 64'd0);
        check("rst out_idx", 64'(out_idx), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst overflow", 64'(overflow), 64'd0);
        check("rst drop_cnt", 64'(drop_cnt), 64'd0);
        check("rst frame_done", 64'(frame_done), 64'd0);
        #11 rst_n = 1'b1;
        tick();
        tick();

        // Single frame, ready held high: element 0 at t+2, frame_done at t+14
        out_ready = 1'b1;
        capture(64'h1000, 1'b1, 2);
        check("single busy t+1", 64'(busy), 64'd1);
        check("single valid t+1", 64'(out_valid), 64'd0);
        wait_drain("single");

        // Back-pressure: ready toggles every cycle
        capture(64'h1000, 1'b1, -1);
        for (int i = 0; i < 80 && (busy || sb.size() != 0); i++) begin
            out_ready = ~out_ready;
            tick();
        end
        out_ready = 1'b1;
        wait_drain("backpressure");

        // Ping-pong: captures three cycles apart, B follows A with no bubble
        capture(64'hA0, 1'b1, 2);
        tick();
        tick();
        capture(64'hB0, 1'b1, 11);
        wait_drain("pingpong");

        // Simultaneous capture and release with both banks full
        out_ready = 1'b0;
        capture(64'h1A0, 1'b1, -1);
        tick();
        capture(64'h1B0, 1'b1, -1);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 40 && !(out_valid && out_idx == 4'd11); i++) tick();
        check("reach A last", 64'(out_idx), 64'd11);
        capture(64'h1C0, 1'b1, -1);
        check("simul overflow", 64'(overflow), 64'd0);
        check("simul drop_cnt", 64'(drop_cnt), 64'd0);
        check("simul busy", 64'(busy), 64'd1);
        wait_drain("simul");

        // Overflow: third capture dropped while consumer stalls
        out_ready = 1'b0;
        capture(64'hA00, 1'b1, -1);
        tick();
        tick();
        capture(64'hB00, 1'b1, -1);
        tick();
        tick();
        capture(64'hC00, 1'b0, -1);
        tick();
        check("ovf overflow", 64'(overflow), 64'd1);
        check("ovf drop_cnt", 64'(drop_cnt), 64'd1);
        out_ready = 1'b1;
        wait_drain("overflow");
        check("ovf sticky", 64'(overflow), 64'd1);

        // Reset mid-frame with SCU_Done held high
        capture(64'h2000, 1'b1, -1);
        for (int i = 0; i < 20 && !(out_valid && out_idx == 4'd5); i++) tick();
        check("reach idx 5", 64'(out_idx), 64'd5);
        SCU_Done = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("mid rst out_valid", 64'(out_valid), 64'd0);
        check("mid rst out_data", out_data, 64'd0);
        check("mid rst out_idx", 64'(out_idx), 64'd0);
        check("mid rst busy", 64'(busy), 64'd0);
        check("mid rst overflow", 64'(overflow), 64'd0);
        check("mid rst drop_cnt", 64'(drop_cnt), 64'd0);
        sb.delete();
        tick();
        tick();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("held done busy", 64'(busy), 64'd0);
        check("held done valid", 64'(out_valid), 64'd0);
        SCU_Done = 1'b0;
        tick();
        capture(64'h3000, 1'b1, 2);
        wait_drain("post reset");

        check("frame_done pulses", 64'(fd_seen), 64'd10);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
